// File: rtl/cmd_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmd_rr_arbiter_pkg
// Description : Shared defaults and state encoding for the command
//               round-robin arbiter and its priority picker.
// Revision    : 1.0 - initial release
// ============================================================================
package cmd_rr_arbiter_pkg;

  // Default number of requesters and payload width.
  localparam int unsigned c_N_REQ_DEFAULT = 4;
  localparam int unsigned c_CMD_W_DEFAULT = 32;

  // Arbiter state: IDLE searches round-robin, LOCKED holds one requester
  // until the final beat of its burst is accepted.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

endpackage : cmd_rr_arbiter_pkg
`default_nettype wire

// File: rtl/cmd_rr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Rotating-priority picker. Selects the first set bit of the
//               request mask, searching upward from (pointer+1) mod N with
//               wrap-around. Purely combinational.
// Ports       : i_req   [N-1:0]  request mask
//               i_ptr   [IW-1:0] last granted index (search starts after it)
//               o_grant [N-1:0]  one-hot grant (all-zero when no request)
//               o_idx   [IW-1:0] index of the granted bit (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_cand;

  // Walk the candidates from the farthest (offset N, the pointer itself)
  // down to the nearest (offset 1). Later hits overwrite earlier ones, so
  // the requester closest after the pointer ends up winning.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = int'(N); k >= 1; k--) begin
      w_cand = IW'((int'(i_ptr) + k) % int'(N));
      if (i_req[w_cand]) begin
        o_grant         = '0;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/cmd_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cmd_rr_arbiter
// Description : Burst-aware round-robin command arbiter. N_REQ requesters
//               offer command beats; one is accepted per cycle into a single
//               registered output slot. A burst (beats up to req_last) from
//               one requester is never interleaved with other requesters.
// Ports       : CLK        clock, rising edge
//               RST_n      asynchronous active-low reset
//               req_valid  [N_REQ]        per-requester beat valid
//               req_cmd    [N_REQ*CMD_W]  payloads, requester i at [i*CMD_W +: CMD_W]
//               req_last   [N_REQ]        final-beat marker
//               req_ready  [N_REQ]        beat accepted this cycle (one-hot or zero)
//               out_valid/out_cmd/out_src/out_last  registered output beat
//               out_ready  downstream accepts the output beat
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_rr_arbiter
  import cmd_rr_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ   = c_N_REQ_DEFAULT,
  parameter  int unsigned CMD_W   = c_CMD_W_DEFAULT,
  localparam int unsigned c_SRC_W = $clog2(N_REQ)
) (
  input  logic                   CLK,
  input  logic                   RST_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*CMD_W-1:0] req_cmd,
  input  logic [N_REQ-1:0]       req_last,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [CMD_W-1:0]       out_cmd,
  output logic [c_SRC_W-1:0]     out_src,
  output logic                   out_last,
  input  logic                   out_ready
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  // While LOCKED this also names the locked requester: the lock is taken on
  // an IDLE acceptance, which loads the pointer, and LOCKED never moves it.
  logic [c_SRC_W-1:0]   r_last_grant;

  logic                 r_out_valid;
  logic [CMD_W-1:0]     r_out_cmd;
  logic [c_SRC_W-1:0]   r_out_src;
  logic                 r_out_last;

  // --------------------------------------------------------------------------
  // Grant selection
  // --------------------------------------------------------------------------
  logic [N_REQ-1:0]     w_pick_grant;
  logic [c_SRC_W-1:0]   w_pick_idx;
  logic [N_REQ-1:0]     w_lock_mask;
  logic [N_REQ-1:0]     w_grant_mask;
  logic [c_SRC_W-1:0]   w_grant_idx;
  logic                 w_slot_free;
  logic                 w_accept;
  logic                 w_acc_last;
  logic [CMD_W-1:0]     w_acc_cmd;
  logic [CMD_W-1:0]     w_cmd_arr [N_REQ];

  for (genvar gi = 0; gi < int'(N_REQ); gi++) begin : g_unpack
    assign w_cmd_arr[gi] = req_cmd[gi*CMD_W +: CMD_W];
  end

  rr_pick #(
    .N  (N_REQ),
    .IW (c_SRC_W)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_last_grant),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx)
  );

  assign w_lock_mask  = N_REQ'(1) << r_last_grant;
  assign w_grant_mask = (r_state == ST_LOCKED) ? (req_valid & w_lock_mask) : w_pick_grant;
  assign w_grant_idx  = (r_state == ST_LOCKED) ? r_last_grant : w_pick_idx;

  assign w_slot_free  = !r_out_valid || out_ready;
  assign w_accept     = w_slot_free && (|w_grant_mask);
  assign w_acc_last   = req_last[w_grant_idx];
  assign w_acc_cmd    = w_cmd_arr[w_grant_idx];

  // Gated by RST_n so nothing looks accepted while the arbiter is held in reset.
  assign req_ready    = (w_slot_free && RST_n) ? w_grant_mask : '0;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept && !w_acc_last) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_accept &&  w_acc_last) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Pointer: only IDLE acceptances rotate priority.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_last_grant <= c_SRC_W'(N_REQ - 1);
    end else if (w_accept && (r_state == ST_IDLE)) begin
      r_last_grant <= w_pick_idx;
    end
  end

  // --------------------------------------------------------------------------
  // Output slot: reload on acceptance (even while the old beat drains, so
  // back-to-back beats flow without a bubble), otherwise clear on transfer.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_out_valid <= 1'b0;
      r_out_cmd   <= '0;
      r_out_src   <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_cmd   <= w_acc_cmd;
      r_out_src   <= w_grant_idx;
      r_out_last  <= w_acc_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_cmd   = r_out_cmd;
  assign out_src   = r_out_src;
  assign out_last  = r_out_last;

endmodule : cmd_rr_arbiter
`default_nettype wire

// File: tb/tb_cmd_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_rr_arbiter
// Description : Self-checking bench for cmd_rr_arbiter: a directed vector
//               table, hand-written multi-cycle corner cases, and a random
//               traffic phase checked against a behavioural model and a
//               per-source scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_rr_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           CLK   = 1'b0;
  logic           RST_n = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_cmd;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_cmd;
  logic [1:0]     out_src;
  logic           out_last;
  logic           out_ready;

  int total = 0;
  int bad   = 0;

  cmd_rr_arbiter #(.N_REQ(N), .CMD_W(W)) dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_cmd   (out_cmd),
    .out_src   (out_src),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [W-1:0] tcmd(input int i);
    return 32'hCAFE_0000 | W'(i);
  endfunction

  task automatic load_tcmds();
    for (int i = 0; i < N; i++) req_cmd[i*W +: W] = tcmd(i);
  endtask

  // Reset with every requester asserting valid: nothing may be accepted.
  task automatic reset_dut();
    req_valid = '1;
    req_last  = '1;
    out_ready = 1'b1;
    load_tcmds();
    RST_n     = 1'b0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'(0));
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_cmd",   64'(out_cmd),   64'(0));
    chk("rst_out_src",   64'(out_src),   64'(0));
    chk("rst_out_last",  64'(out_last),  64'(0));
    req_valid = '0;
    RST_n     = 1'b1;
  endtask

  // Drive one cycle of inputs, check req_ready before the edge and the
  // registered output after it.
  task automatic cycle(input string nm, input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic ord, input logic [N-1:0] e_rdy,
                       input logic e_ov, input int e_src, input logic e_last);
    req_valid = v;
    req_last  = l;
    out_ready = ord;
    #3;
    chk({nm, "_ready"}, 64'(req_ready), 64'(e_rdy));
    tick();
    chk({nm, "_ov"}, 64'(out_valid), 64'(e_ov));
    if (e_ov) begin
      chk({nm, "_src"},  64'(out_src),  64'(e_src));
      chk({nm, "_cmd"},  64'(out_cmd),  64'(tcmd(e_src)));
      chk({nm, "_last"}, 64'(out_last), 64'(e_last));
    end
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] last;
    logic         oready;
    logic [N-1:0] exp_ready;
    logic         exp_ov;
    int           exp_src;
    logic         exp_olast;
  } vec_t;

  typedef struct packed {
    logic [W-1:0] cmd;
    logic         last;
  } beat_t;

  vec_t  vt[11];
  beat_t sb_q[N][$];
  beat_t cur[N];
  bit    have[N];
  int    seqn[N];

  initial begin
    // Model and scoreboard state for the random phase.
    bit           m_locked;
    int           m_owner;
    int           m_last;
    bit           m_ov;
    logic [W-1:0] m_cmd;
    int           m_src;
    bit           m_olast;
    bit           m_free;
    int           g;
    bit           burst_open;
    int           burst_src;
    int           beats_out;
    logic [N-1:0] exp_ready;
    beat_t        exp_b;

    req_valid = '0;
    req_last  = '0;
    req_cmd   = '0;
    out_ready = 1'b0;
    #2;

    // ---------------- Directed table: rotation, then a locked burst ------------
    //          valid    last     ord   ready    ov    src  olast
    vt[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 0, 1'b1};
    vt[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 1, 1'b1};
    vt[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2, 1'b1};
    vt[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 3, 1'b1};
    vt[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 0, 1'b1};
    vt[5]  = '{4'b0111, 4'b1101, 1'b1, 4'b0010, 1'b1, 1, 1'b0};
    vt[6]  = '{4'b0111, 4'b1101, 1'b1, 4'b0010, 1'b1, 1, 1'b0};
    vt[7]  = '{4'b0111, 4'b1111, 1'b1, 4'b0010, 1'b1, 1, 1'b1};
    vt[8]  = '{4'b0111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2, 1'b1};
    vt[9]  = '{4'b0111, 4'b1111, 1'b1, 4'b0001, 1'b1, 0, 1'b1};
    vt[10] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b0};

    reset_dut();
    for (int i = 0; i < 11; i++) begin
      cycle($sformatf("vec%0d", i), vt[i].valid, vt[i].last, vt[i].oready,
            vt[i].exp_ready, vt[i].exp_ov, vt[i].exp_src, vt[i].exp_olast);
    end

    // ---------------- Back-pressure: hold the beat, then no bubble --------------
    reset_dut();
    cycle("stall_a", 4'b0001, 4'b1111, 1'b1, 4'b0001, 1'b1, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle($sformatf("stall_hold%0d", i), 4'b0010, 4'b1111, 1'b0, 4'b0000, 1'b1, 0, 1'b1);
    end
    cycle("stall_rel", 4'b0010, 4'b1111, 1'b1, 4'b0010, 1'b1, 1, 1'b1);
    cycle("stall_drain", 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 0, 1'b0);

    // ---------------- Wrap-around search from last_grant=3 ----------------------
    reset_dut();
    cycle("wrap_a", 4'b1000, 4'b1111, 1'b1, 4'b1000, 1'b1, 3, 1'b1);
    cycle("wrap_b", 4'b1000, 4'b1111, 1'b1, 4'b1000, 1'b1, 3, 1'b1);
    cycle("wrap_idle", 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 0, 1'b0);

    // ---------------- Reset during beat 2 of a locked burst ---------------------
    reset_dut();
    cycle("rstlk_b1", 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2, 1'b0);
    req_valid = 4'b0101;
    req_last  = 4'b0000;
    #3;
    chk("rstlk_b2_ready", 64'(req_ready), 64'(4'b0100));
    RST_n = 1'b0;
    #1;
    chk("rstlk_ov_async", 64'(out_valid), 64'(0));
    chk("rstlk_ready_rst", 64'(req_ready), 64'(0));
    tick();
    RST_n = 1'b1;
    cycle("rstlk_after", 4'b0101, 4'b1111, 1'b1, 4'b0001, 1'b1, 0, 1'b1);

    // ---------------- Random traffic against the reference model ----------------
    reset_dut();
    m_locked   = 1'b0;
    m_owner    = 0;
    m_last     = N - 1;
    m_ov       = 1'b0;
    m_cmd      = '0;
    m_src      = 0;
    m_olast    = 1'b0;
    burst_open = 1'b0;
    burst_src  = 0;
    beats_out  = 0;
    for (int s = 0; s < N; s++) begin
      have[s] = 1'b0;
      seqn[s] = 0;
    end

    for (int cyc = 0; cyc < 10000; cyc++) begin
      // Each requester keeps one beat pending until it is accepted; valid
      // may drop at random, including in the middle of a burst.
      for (int s = 0; s < N; s++) begin
        if (!have[s] && $urandom_range(0, 9) < 6) begin
          cur[s].cmd  = W'((s << 28) | (seqn[s] & 32'h0FFF_FFFF));
          cur[s].last = ($urandom_range(0, 2) == 0);
          seqn[s]++;
          have[s] = 1'b1;
          sb_q[s].push_back(cur[s]);
        end
        req_valid[s]        = have[s] && ($urandom_range(0, 3) != 0);
        req_cmd[s*W +: W]   = cur[s].cmd;
        req_last[s]         = cur[s].last;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #3;

      // Expected grant from the arbitration rules.
      m_free = !m_ov || out_ready;
      g = -1;
      if (m_locked) begin
        if (req_valid[m_owner]) g = m_owner;
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
        end
      end
      if (!m_free) g = -1;
      exp_ready = (g >= 0) ? N'(1 << g) : '0;
      chk("rnd_ready", 64'(req_ready), 64'(exp_ready));

      // Output-side scoreboard: per-source order and no burst interleaving.
      if (out_valid && out_ready) begin
        beats_out++;
        if (sb_q[out_src].size() == 0) begin
          chk("rnd_sb_empty", 64'(sb_q[out_src].size()), 64'(1));
        end else begin
          exp_b = sb_q[out_src].pop_front();
          chk("rnd_sb_cmd",  64'(out_cmd),  64'(exp_b.cmd));
          chk("rnd_sb_last", 64'(out_last), 64'(exp_b.last));
        end
        if (burst_open) chk("rnd_interleave", 64'(out_src), 64'(burst_src));
        burst_open = !out_last;
        burst_src  = int'(out_src);
      end

      tick();

      if (g >= 0) begin
        m_ov    = 1'b1;
        m_cmd   = cur[g].cmd;
        m_src   = g;
        m_olast = cur[g].last;
        if (m_locked) begin
          if (cur[g].last) m_locked = 1'b0;
        end else begin
          m_last = g;
          if (!cur[g].last) begin
            m_locked = 1'b1;
            m_owner  = g;
          end
        end
        have[g] = 1'b0;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end

      chk("rnd_ov", 64'(out_valid), 64'(m_ov));
      if (m_ov) begin
        chk("rnd_cmd",  64'(out_cmd),  64'(m_cmd));
        chk("rnd_src",  64'(out_src),  64'(m_src));
        chk("rnd_last", 64'(out_last), 64'(m_olast));
      end
    end
    chk("rnd_traffic_flowed", 64'(beats_out > 1000), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cmd_rr_arbiter
`default_nettype wire

// File: doc/cmd_rr_arbiter.md
CMD_RR_ARBITER -- requirements
Module: cmd_rr_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of command requesters (2..8).
REQ-002 SHALL have parameter CMD_W, default 32, command payload width in bits.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port RST_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  N_REQ  per-requester command-beat valid.
REQ-006 SHALL have port req_cmd  input  N_REQ*CMD_W  per-requester payload; requester i occupies bits [i*CMD_W +: CMD_W].
REQ-007 SHALL have port req_last  input  N_REQ  per-requester marker for the final beat of a burst.
REQ-008 SHALL have port req_ready  output  N_REQ  per-requester beat accepted this cycle.
REQ-009 SHALL have port out_valid  output  1  registered output beat valid.
REQ-010 SHALL have port out_cmd  output  CMD_W  registered payload.
REQ-011 SHALL have port out_src  output  clog2(N_REQ)  index of the requester that supplied the beat.
REQ-012 SHALL have port out_last  output  1  registered copy of req_last.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the beat.

Function
REQ-014 A beat transfers on a port when its valid and ready are both high at a rising CLK edge.
REQ-015 Output slot free = !out_valid || out_ready.
REQ-016 At most one req_ready bit is high per cycle, and only when the slot is free and the granted requester's req_valid is high.
REQ-017 req_ready SHALL be combinational from req_valid, the state, the pointer and out_ready; it SHALL NOT depend on req_cmd.
REQ-018 Latency is 1 cycle: a beat accepted at edge k appears on out_* after edge k, with out_src set to the grantee.
REQ-019 out_valid SHALL stay high with out_* stable until out_ready is high; it SHALL clear on a transfer with no new acceptance.
REQ-020 A simultaneous out transfer and new acceptance SHALL reload out_* without a bubble, giving 1 beat/cycle throughput.
REQ-021 State machine IDLE: the grantee is the first asserted req_valid, searching from (last_grant+1) mod N_REQ upward with wrap-around.
REQ-022 In IDLE, acceptance with req_last=1 SHALL stay in IDLE; with req_last=0 SHALL go to LOCKED on that requester.
REQ-023 In LOCKED, only the locked requester can be granted; other requests wait, regardless of priority.
REQ-024 Acceptance of the locked requester's req_last=1 beat SHALL return to IDLE.
REQ-025 last_grant SHALL update to the grantee on every IDLE acceptance; it SHALL NOT change in LOCKED.
REQ-026 When no req_valid is set, or the slot is not free, there is no acceptance and state and pointer hold.
REQ-027 A requester deasserting valid mid-burst SHALL leave the arbiter LOCKED, waiting with no timeout.

Reset
REQ-028 RST_n low SHALL immediately force: state=IDLE, last_grant=N_REQ-1 (requester 0 highest), out_valid=0, out_cmd=0, out_src=0, out_last=0.
REQ-029 req_ready SHALL be all-zero while RST_n is low.
REQ-030 Reset mid-burst SHALL discard the lock and any held output beat.

Structure
REQ-031 A shared package SHALL hold the defaults for N_REQ and CMD_W, and the state encoding IDLE=1'b0, LOCKED=1'b1.
REQ-032 The rotating priority search SHALL be the sub-module rr_pick (inputs: request mask and pointer; outputs: one-hot grant and index).
REQ-033 All flops SHALL follow the async active-low reset form of the cell-library DFF.

Verification
REQ-034 Reset, then all four req_valid high with req_last=1 and out_ready=1 -> out_src sequence is 0,1,2,3,0 on consecutive cycles.
REQ-035 req1 sends a 3-beat burst (last on beat 3) while req0 and req2 are valid -> out_src=1,1,1, then 2, then 0.
REQ-036 out_ready=0 for 4 cycles with out_valid=1 -> out_cmd is stable, req_ready=0, and no beat is lost or duplicated after release.
REQ-037 Only req3 is valid with last_grant=3 -> wrap-around search grants req3 the next cycle.
REQ-038 Assert RST_n low during beat 2 of a LOCKED burst -> out_valid=0 immediately; after release, req0 is granted first.
REQ-039 Random valid/ready traffic for 10k cycles -> the scoreboard sees per-source beat order preserved and no burst interleaving.
